// File: rtl/tybec_leaf_pkg.sv
// Shared definitions for TyBEC leaf map nodes: operator encodings and
// counter width helper.
package tybec_leaf_pkg;

    // Operator selected by a leaf node.
    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } op_e;

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tybec_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. Pointers wrap modulo DEPTH, so
// DEPTH need not be a power of two. rdata reads 0 while the FIFO is empty.
module tybec_sync_fifo_fwft
    import tybec_leaf_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = cnt_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rdata = empty ? '0 : mem[rptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and fill-count registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= ptr_inc(wptr);
            if (do_rd) rptr <= ptr_inc(rptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the array is deliberately not reset; empty masks stale entries
    // and leaving reset off lets the storage map onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/tybec_map_leaf_elastic.sv
// TyBEC leaf map node: binary mul/add/sub on one or two joined streams with
// a free-running operator pipeline and a credit-counted output FIFO. iready
// depends only on registered occupancy, never on oready.
module tybec_map_leaf_elastic
    import tybec_leaf_pkg::*;
#(
    parameter int               DATAW     = 34,
    parameter int               LAT       = 3,
    parameter int               OP        = 0,
    parameter int               USE_CONST = 1,
    parameter logic [DATAW-1:0] CONST_VAL = '0,
    parameter int               DEPTH     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid_in1,
    input  logic [DATAW-1:0] in1,
    input  logic             ivalid_in2,
    input  logic [DATAW-1:0] in2,
    output logic             iready,
    output logic             ovalid,
    output logic [DATAW-1:0] out1,
    input  logic             oready
);

    localparam int  OCC_W  = cnt_w(DEPTH + 1);
    localparam op_e OP_SEL = op_e'(OP[1:0]);

    if (LAT < 1 || LAT > 16) begin : g_bad_lat
        $error("tybec_map_leaf_elastic: LAT must be in 1..16");
    end
    if (DEPTH < LAT + 1) begin : g_bad_depth
        $error("tybec_map_leaf_elastic: DEPTH must be at least LAT+1");
    end

    logic             ivalid;
    logic             accept;
    logic             pop;
    logic [DATAW-1:0] op_b;
    logic [DATAW-1:0] op_res;
    logic [LAT-1:0]   pipe_v;
    logic [DATAW-1:0] pipe_d [LAT];
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    logic             iready_q;
    logic             fifo_empty;
    logic             fifo_full;

    // Both channels are consumed together; with a constant operand only in1 gates.
    assign ivalid = ivalid_in1 && ((USE_CONST != 0) || ivalid_in2);
    assign accept = ivalid && iready_q;
    assign iready = iready_q;
    assign ovalid = !fifo_empty;
    assign pop    = ovalid && oready;

    // Operand select and arithmetic; results wrap modulo 2^DATAW.
    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        op_b = in2;
        if (USE_CONST != 0) op_b = CONST_VAL;
        case (OP_SEL)
            OP_ADD:  op_res = in1 + op_b;
            OP_SUB:  op_res = in1 - op_b;
            default: op_res = in1 * op_b;
        endcase
    end

    // Free-running operator pipeline; stage 0 is the input register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_v <= '0;
            for (int i = 0; i < LAT; i++) pipe_d[i] <= '0;
        end else begin
            pipe_v[0] <= accept;
            pipe_d[0] <= op_res;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    // Next occupancy: items in flight plus items buffered.
    always_comb begin
        occ_next = occ;
        case ({accept, pop})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    // Credit counter and registered ready; ready stays low through reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ      <= '0;
            iready_q <= 1'b0;
        end else begin
            occ      <= occ_next;
            iready_q <= (occ_next < OCC_W'(DEPTH));
        end
    end

    tybec_sync_fifo_fwft #(
        .WIDTH (DATAW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (pipe_v[LAT-1]),
        .wdata (pipe_d[LAT-1]),
        .rd    (pop),
        .rdata (out1),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Credits guarantee the FIFO always has room for the pipeline tail.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(pipe_v[LAT-1] && fifo_full));

endmodule

// File: tb/tb_tybec_map_leaf_elastic.sv
// Scoreboard bench for tybec_map_leaf_elastic: four instances cover const
// mul, stream add (with backpressure, join skew and mid-stream reset),
// 8-bit wrapping sub and 8-bit wrapping mul.
module tb_tybec_map_leaf_elastic;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Constant-operand multiplier, 34 bits.
    logic m_v1 = 0, m_v2 = 0, m_irdy, m_ov, m_ordy = 1;
    logic [33:0] m_in1 = '0, m_in2 = '0, m_out;
    // Two-stream adder, 34 bits.
    logic a_v1 = 0, a_v2 = 0, a_irdy, a_ov, a_ordy = 1;
    logic [33:0] a_in1 = '0, a_in2 = '0, a_out;
    // Two-stream subtractor, 8 bits, odd DEPTH.
    logic s_v1 = 0, s_v2 = 0, s_irdy, s_ov, s_ordy = 1;
    logic [7:0] s_in1 = '0, s_in2 = '0, s_out;
    // Two-stream multiplier, 8 bits, LAT=1.
    logic x_v1 = 0, x_v2 = 0, x_irdy, x_ov, x_ordy = 1;
    logic [7:0] x_in1 = '0, x_in2 = '0, x_out;

    logic [33:0] q_m[$], q_a[$];
    logic [7:0]  q_s[$], q_x[$];

    typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] y; } vec8_t;
    vec8_t sub_vec[8] = '{
        '{8'd3,   8'd5,   8'hFE}, '{8'd200, 8'd1,   8'hC7},
        '{8'd0,   8'd1,   8'hFF}, '{8'd5,   8'd3,   8'h02},
        '{8'd128, 8'd1,   8'h7F}, '{8'd10,  8'd10,  8'h00},
        '{8'd1,   8'd255, 8'h02}, '{8'd255, 8'd0,   8'hFF}};
    vec8_t mul_vec[6] = '{
        '{8'h20, 8'h10, 8'h00}, '{8'h0F, 8'h11, 8'hFF},
        '{8'h03, 8'h07, 8'h15}, '{8'h80, 8'h02, 8'h00},
        '{8'hFF, 8'hFF, 8'h01}, '{8'h10, 8'h0F, 8'hF0}};

    tybec_map_leaf_elastic #(.DATAW(34), .LAT(3), .OP(0), .USE_CONST(1),
        .CONST_VAL(34'd5), .DEPTH(8)) u_mul (
        .clk(clk), .rst(rst), .ivalid_in1(m_v1), .in1(m_in1), .ivalid_in2(m_v2),
        .in2(m_in2), .iready(m_irdy), .ovalid(m_ov), .out1(m_out), .oready(m_ordy));

    tybec_map_leaf_elastic #(.DATAW(34), .LAT(3), .OP(1), .USE_CONST(0),
        .CONST_VAL(34'd0), .DEPTH(8)) u_add (
        .clk(clk), .rst(rst), .ivalid_in1(a_v1), .in1(a_in1), .ivalid_in2(a_v2),
        .in2(a_in2), .iready(a_irdy), .ovalid(a_ov), .out1(a_out), .oready(a_ordy));

    tybec_map_leaf_elastic #(.DATAW(8), .LAT(2), .OP(2), .USE_CONST(0),
        .CONST_VAL(8'd0), .DEPTH(5)) u_sub8 (
        .clk(clk), .rst(rst), .ivalid_in1(s_v1), .in1(s_in1), .ivalid_in2(s_v2),
        .in2(s_in2), .iready(s_irdy), .ovalid(s_ov), .out1(s_out), .oready(s_ordy));

    tybec_map_leaf_elastic #(.DATAW(8), .LAT(1), .OP(0), .USE_CONST(0),
        .CONST_VAL(8'd0), .DEPTH(3)) u_mul8 (
        .clk(clk), .rst(rst), .ivalid_in1(x_v1), .in1(x_in1), .ivalid_in2(x_v2),
        .in2(x_in2), .iready(x_irdy), .ovalid(x_ov), .out1(x_out), .oready(x_ordy));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qtotal();
        return q_m.size() + q_a.size() + q_s.size() + q_x.size();
    endfunction

    task automatic drain(input int max_cycles);
        for (int c = 0; c < max_cycles && qtotal() != 0; c++) @(posedge clk);
        check("drain", 64'(qtotal()), 64'd0);
        #1;
    endtask

    // Monitors: whenever a result is presented it must match the queue head;
    // it is popped only when the handshake completes.
    always @(negedge clk) if (m_ov === 1'b1) begin
        if (q_m.size() == 0) check("mul_spurious", m_ov, 1'b0);
        else begin
            check("mul_out", m_out, q_m[0]);
            if (m_ordy) void'(q_m.pop_front());
        end
    end
    always @(negedge clk) if (a_ov === 1'b1) begin
        if (q_a.size() == 0) check("add_spurious", a_ov, 1'b0);
        else begin
            check("add_out", a_out, q_a[0]);
            if (a_ordy) void'(q_a.pop_front());
        end
    end
    always @(negedge clk) if (s_ov === 1'b1) begin
        if (q_s.size() == 0) check("sub8_spurious", s_ov, 1'b0);
        else begin
            check("sub8_out", s_out, q_s[0]);
            if (s_ordy) void'(q_s.pop_front());
        end
    end
    always @(negedge clk) if (x_ov === 1'b1) begin
        if (q_x.size() == 0) check("mul8_spurious", x_ov, 1'b0);
        else begin
            check("mul8_out", x_out, q_x[0]);
            if (x_ordy) void'(q_x.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_iready_mul", m_irdy, 1'b0);
        check("rst_iready_add", a_irdy, 1'b0);
        check("rst_ovalid_add", a_ov, 1'b0);
        check("rst_out1_mul", m_out, 34'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_iready_mul", m_irdy, 1'b1);
        check("post_rst_iready_add", a_irdy, 1'b1);
        @(posedge clk); #1;

        // Single const multiply: 7*5 valid only in the cycle after edge 3.
        m_v1 = 1'b1; m_in1 = 34'd7;
        @(negedge clk);
        if (m_irdy) q_m.push_back(34'd35);
        @(posedge clk); #1;
        m_v1 = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            check("mul_latency_ovalid", m_ov, (c == 3));
            if (c == 3) check("mul_latency_out1", m_out, 34'd35);
            @(posedge clk);
        end
        #1;
        drain(10);

        // Back-to-back add stream, no bubbles once the pipeline fills.
        for (int i = 0; i < 64; i++) begin
            a_v1 = 1'b1; a_v2 = 1'b1; a_in1 = 34'(i); a_in2 = 34'd100;
            @(negedge clk);
            check("stream_iready", a_irdy, 1'b1);
            if (i >= 4) check("stream_nobubble", a_ov, 1'b1);
            if (a_irdy) q_a.push_back(34'(100 + i));
            @(posedge clk); #1;
        end
        a_v1 = 1'b0; a_v2 = 1'b0;
        drain(20);

        // Backpressure fill: exactly DEPTH accepts, then one pop frees one slot.
        a_ordy = 1'b0; acc = 0;
        for (int j = 0; j < 12; j++) begin
            a_v1 = 1'b1; a_v2 = 1'b1; a_in1 = 34'(j); a_in2 = 34'd1000;
            @(negedge clk);
            if (a_irdy) begin
                acc++;
                q_a.push_back(34'(1000 + j));
            end
            @(posedge clk); #1;
        end
        check("bp_accepts", 64'(acc), 64'd8);
        @(negedge clk);
        check("bp_iready_low", a_irdy, 1'b0);
        check("bp_ovalid", a_ov, 1'b1);
        check("bp_head", a_out, 34'd1000);
        @(posedge clk); #1;
        a_ordy = 1'b1; a_in1 = 34'd99;
        @(negedge clk);
        check("bp_iready_during_pop", a_irdy, 1'b0);
        @(posedge clk); #1;
        a_ordy = 1'b0;
        @(negedge clk);
        check("bp_reaccept", a_irdy, 1'b1);
        if (a_irdy) q_a.push_back(34'd1099);
        @(posedge clk); #1;
        a_v1 = 1'b0; a_v2 = 1'b0;
        @(negedge clk);
        check("bp_full_again", a_irdy, 1'b0);
        @(posedge clk); #1;
        a_ordy = 1'b1;
        drain(30);

        // Join skew: in1 waits four cycles for in2; exactly one result.
        a_v1 = 1'b1; a_in1 = 34'd11; a_v2 = 1'b0; a_in2 = 34'd7;
        repeat (4) begin
            @(negedge clk);
            check("join_iready", a_irdy, 1'b1);
            @(posedge clk); #1;
        end
        a_v2 = 1'b1; a_in2 = 34'd22;
        @(negedge clk);
        if (a_irdy) q_a.push_back(34'd33);
        @(posedge clk); #1;
        a_v1 = 1'b0; a_v2 = 1'b0;
        drain(10);
        repeat (6) @(posedge clk);
        #1;

        // 8-bit wrapping subtract, streamed through an odd-depth FIFO.
        for (int i = 0; i < 8; i++) begin
            s_v1 = 1'b1; s_v2 = 1'b1; s_in1 = sub_vec[i].a; s_in2 = sub_vec[i].b;
            @(negedge clk);
            check("sub8_iready", s_irdy, 1'b1);
            if (s_irdy) q_s.push_back(sub_vec[i].y);
            @(posedge clk); #1;
        end
        s_v1 = 1'b0; s_v2 = 1'b0;
        drain(10);

        // 8-bit wrapping multiply, LAT=1.
        for (int i = 0; i < 6; i++) begin
            x_v1 = 1'b1; x_v2 = 1'b1; x_in1 = mul_vec[i].a; x_in2 = mul_vec[i].b;
            @(negedge clk);
            check("mul8_iready", x_irdy, 1'b1);
            if (x_irdy) q_x.push_back(mul_vec[i].y);
            @(posedge clk); #1;
        end
        x_v1 = 1'b0; x_v2 = 1'b0;
        drain(10);

        // Reset mid-stream: five items in flight or buffered are dropped.
        a_ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_v1 = 1'b1; a_v2 = 1'b1; a_in1 = 34'(50 + i); a_in2 = 34'd0;
            @(negedge clk);
            if (a_irdy) q_a.push_back(34'(50 + i));
            @(posedge clk); #1;
        end
        a_v1 = 1'b0; a_v2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        q_a.delete();
        rst = 1'b1; a_ordy = 1'b1;
        @(negedge clk);
        check("midrst_ovalid", a_ov, 1'b0);
        check("midrst_out1", a_out, 34'd0);
        check("midrst_iready", a_irdy, 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("midrst_no_stale", a_ov, 1'b0);
            if (c == 0) check("midrst_iready_back", a_irdy, 1'b1);
        end
        @(posedge clk); #1;
        a_v1 = 1'b1; a_v2 = 1'b1; a_in1 = 34'd40; a_in2 = 34'd2;
        @(negedge clk);
        if (a_irdy) q_a.push_back(34'd42);
        @(posedge clk); #1;
        a_v1 = 1'b0; a_v2 = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            check("midrst_new_latency", a_ov, (c == 3));
            @(posedge clk);
        end
        #1;
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
